// File: rtl/uart_receiver.sv
// UART receive stage: 8N1 deserializer with a valid/read-acknowledge handshake
// and sticky framing-error and overrun flags.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_LEN     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                data_in,
  input  logic                re,
  input  logic                err_clr,
  output logic [DATA_LEN-1:0] data_out,
  output logic                valid,
  output logic                frame_err,
  output logic                overrun,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          sync_q;
  logic                rx_s;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_LEN-1:0] shift_q, shift_d;
  logic [DATA_LEN-1:0] data_out_d;
  logic                valid_d;
  logic                frame_err_d;
  logic                overrun_d;

  // Two-flop synchronizer; idle-high so reset does not look like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], data_in};
    end
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_out  <= data_out_d;
      valid     <= valid_d;
      frame_err <= frame_err_d;
      overrun   <= overrun_d;
    end
  end

  // Next-state logic; clears are applied first so coincident error events win
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_out_d  = data_out;
    valid_d     = valid & ~re;
    frame_err_d = frame_err & ~err_clr;
    overrun_d   = overrun & ~err_clr;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end else begin
            state_d = IDLE;
            if (!valid || re) begin
              data_out_d = shift_q;
              valid_d    = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized bench for uart_receiver: frames are driven bit-serially and the
// handshake/flag outcome of each frame is predicted by a byte-level model.
module tb_uart_receiver;

  localparam int CPB = 16;
  localparam int DLEN = 8;
  // Negedge index (from the start-bit drive) at which a stop-bit outcome is visible:
  // 2 sync flops + 1 detect cycle, half a bit to mid start, 9 full bits to mid stop.
  localparam int LOAD_C = 3 + CPB / 2 + 9 * CPB;

  logic            clk;
  logic            rst_n;
  logic            data_in;
  logic            re;
  logic            err_clr;
  logic [DLEN-1:0] data_out;
  logic            valid;
  logic            frame_err;
  logic            overrun;
  logic            busy;

  uart_receiver #(
    .CLKS_PER_BIT(CPB),
    .DATA_LEN    (DLEN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .re       (re),
    .err_clr  (err_clr),
    .data_out (data_out),
    .valid    (valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Byte-level reference state
  logic [7:0] exp_data;
  logic       exp_valid;
  logic       exp_fe;
  logic       exp_ov;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_data"}, 32'(data_out), 32'(exp_data));
    check({tag, "_valid"}, 32'(valid), 32'(exp_valid));
    check({tag, "_ferr"}, 32'(frame_err), 32'(exp_fe));
    check({tag, "_ovr"}, 32'(overrun), 32'(exp_ov));
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      data_in = 1'b1;
      re      = 1'b0;
      err_clr = 1'b0;
    end
  endtask

  // Drive one frame; stop_low extra bit periods hold the stop bit low.
  // re_c / err_c / abort_c: negedge index for a 1-cycle pulse, or -1 for none.
  task automatic send_frame(input logic [7:0] b, input int stop_low, input int re_c,
                            input int err_c, input int abort_c);
    int  total;
    int  idx;
    bit  good;
    bit  aborted;
    bit  re_now;
    total   = (10 + stop_low) * CPB;
    good    = (stop_low == 0);
    aborted = 1'b0;
    re_now  = (re_c == LOAD_C - 1);
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      if (!aborted) begin
        if (c == LOAD_C) begin
          if (err_c == LOAD_C - 1) begin
            exp_fe = 1'b0;
            exp_ov = 1'b0;
          end
          if (good) begin
            if (!exp_valid || re_now) begin
              exp_data  = b;
              exp_valid = 1'b1;
            end else begin
              exp_ov = 1'b1;
            end
          end else begin
            exp_fe = 1'b1;
            if (re_now) exp_valid = 1'b0;
          end
          check_all("stop");
          check("stop_busy", 32'(busy), 32'(!good));
        end else begin
          if (re_c >= 0 && c == re_c + 1) begin
            exp_valid = 1'b0;
            check("re_clr", 32'(valid), 32'(exp_valid));
          end
          if (err_c >= 0 && c == err_c + 1) begin
            exp_fe = 1'b0;
            exp_ov = 1'b0;
            check("err_clr_f", 32'(frame_err), 32'(exp_fe));
          end
          if (c == LOAD_C - 1) check("pre_valid", 32'(valid), 32'(exp_valid));
        end
      end else if (c == abort_c + 1) begin
        check_all("abort");
        check("abort_busy", 32'(busy), 32'(0));
      end

      idx = c / CPB;
      if (idx == 0) data_in = 1'b0;
      else if (idx <= 8) data_in = b[idx-1];
      else if (idx < 9 + stop_low) data_in = 1'b0;
      else data_in = 1'b1;
      re      = !aborted && re_c >= 0 && c == re_c;
      err_clr = !aborted && err_c >= 0 && c == err_c;
      if (c == abort_c) begin
        rst_n     = 1'b0;
        aborted   = 1'b1;
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_fe    = 1'b0;
        exp_ov    = 1'b0;
      end
      if (aborted && c == abort_c + 3) rst_n = 1'b1;
    end
  endtask

  task automatic read_byte();
    @(negedge clk);
    re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    exp_valid = 1'b0;
    check("read_valid", 32'(valid), 32'(exp_valid));
  endtask

  task automatic clear_errors();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    check("clr_ferr", 32'(frame_err), 32'(exp_fe));
    check("clr_ovr", 32'(overrun), 32'(exp_ov));
  endtask

  task automatic glitch();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 6) check("glitch_busy_hi", 32'(busy), 32'(1));
      if (c == 29) begin
        check("glitch_busy_lo", 32'(busy), 32'(0));
        check_all("glitch");
      end
      data_in = (c < 5) ? 1'b0 : 1'b1;
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    data_in   = 1'b1;
    re        = 1'b0;
    err_clr   = 1'b0;
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_fe    = 1'b0;
    exp_ov    = 1'b0;

    repeat (3) @(negedge clk);
    check_all("reset");
    check("reset_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    idle(5);

    // Single byte
    send_frame(8'hA5, 0, -1, -1, -1);
    idle(3);
    read_byte();

    glitch();

    // Framing error, then a clean frame right behind it
    send_frame(8'h3C, 3, -1, -1, -1);
    send_frame(8'h11, 0, -1, -1, -1);
    clear_errors();
    read_byte();

    // Overrun
    send_frame(8'h55, 0, -1, -1, -1);
    send_frame(8'hAA, 0, -1, -1, -1);
    clear_errors();
    read_byte();

    // Read acknowledge on the load cycle
    send_frame(8'h55, 0, -1, -1, -1);
    send_frame(8'h0F, 0, LOAD_C - 1, -1, -1);
    read_byte();

    // Error set wins over a coincident clear
    send_frame(8'h42, 1, -1, LOAD_C - 1, -1);
    clear_errors();

    // Reset mid-frame, then zero-gap frames
    send_frame(8'hFF, 0, -1, -1, 60);
    idle(4);
    send_frame(8'h01, 0, -1, -1, -1);
    send_frame(8'h80, 0, 20, -1, -1);
    read_byte();

    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      int sl;
      int rc;
      int ec;
      b  = 8'($urandom);
      sl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      case ($urandom_range(0, 3))
        0:       rc = -1;
        1:       rc = LOAD_C - 1;
        default: rc = int'($urandom_range(0, LOAD_C - 2));
      endcase
      ec = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LOAD_C - 1)) : -1;
      send_frame(b, sl, rc, ec, -1);
      idle(int'($urandom_range(0, 12)));
    end

    idle(4);
    check_all("final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
